// File: rtl/pc_update_if.sv
// Bus bundle for the program-counter stage.
// master: upstream side (branch_control / decode / regfile) plus the
//         consumers of pc, pc_plus4 and status.
// slave : the pc_update block itself.
interface pc_update_if #(
  parameter int XLEN = 32
);
  // Control and operand inputs to the PC stage
  logic            stall;
  logic            taken;
  logic            jalr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;

  // PC outputs and status
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            halted;
  logic            trap_misaligned;
  logic [XLEN-1:0] bad_addr;
  logic [31:0]     retired_cnt;
  logic [31:0]     taken_cnt;

  modport master (
    output stall, taken, jalr, imm, rs1_data,
    input  pc, pc_plus4, halted, trap_misaligned, bad_addr,
           retired_cnt, taken_cnt
  );

  modport slave (
    input  stall, taken, jalr, imm, rs1_data,
    output pc, pc_plus4, halted, trap_misaligned, bad_addr,
           retired_cnt, taken_cnt
  );
endinterface

// File: rtl/pc_update.sv
// Program-counter stage of the single-cycle RISC-V core.
// Computes next PC (branch/jal/jalr target when taken, else pc + 4),
// and enters a sticky HALT state with a one-cycle trap pulse when a taken
// target is not 4-byte aligned. Only reset leaves HALT.
// Optional feature macro: PC_STATS_EN builds the retired/taken counters;
// without it both counter outputs are tied to zero.
module pc_update #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rstn,
  pc_update_if.slave bus
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] bad_addr_reg;
  logic            trap_reg;

  logic [XLEN-1:0] pc_plus4_next;
  logic [XLEN-1:0] base_next;
  logic [XLEN-1:0] sum_next;
  logic [XLEN-1:0] target_next;
  logic            misaligned_next;
  logic            advance_next;

  // Target selection, jalr bit-0 clear, alignment check and retire qualifier
  always_comb begin
    pc_plus4_next   = pc_reg + XLEN'(4);
    base_next       = bus.jalr ? bus.rs1_data : pc_reg;
    sum_next        = base_next + bus.imm;
    target_next     = bus.jalr ? {sum_next[XLEN-1:1], 1'b0} : sum_next;
    // Alignment only matters when the redirect is actually taken
    misaligned_next = bus.taken && (target_next[1:0] != 2'b00);
    advance_next    = (state_reg == S_RUN) && !bus.stall && !misaligned_next;
  end

  // Run/halt state machine with registered PC, trap pulse and bad address
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= S_RUN;
      pc_reg       <= RESET_PC;
      bad_addr_reg <= '0;
      trap_reg     <= 1'b0;
    end else begin
      trap_reg <= 1'b0;
      case (state_reg)
        S_RUN: begin
          if (!bus.stall) begin
            if (misaligned_next) begin
              // PC stays on the faulting instruction
              state_reg    <= S_HALT;
              bad_addr_reg <= target_next;
              trap_reg     <= 1'b1;
            end else begin
              pc_reg <= bus.taken ? target_next : pc_plus4_next;
            end
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_RUN;
        end
      endcase
    end
  end

`ifdef PC_STATS_EN
  logic [31:0] retired_cnt_reg;
  logic [31:0] taken_cnt_reg;

  // Retirement statistics; both counters wrap naturally at 32 bits
  always_ff @(posedge clk) begin
    if (!rstn) begin
      retired_cnt_reg <= '0;
      taken_cnt_reg   <= '0;
    end else if (advance_next) begin
      retired_cnt_reg <= retired_cnt_reg + 32'd1;
      if (bus.taken) begin
        taken_cnt_reg <= taken_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.retired_cnt = retired_cnt_reg;
  assign bus.taken_cnt   = taken_cnt_reg;
`else
  logic unused_advance;
  assign unused_advance  = advance_next;
  assign bus.retired_cnt = 32'd0;
  assign bus.taken_cnt   = 32'd0;
`endif

  assign bus.pc              = pc_reg;
  assign bus.pc_plus4        = pc_plus4_next;
  assign bus.halted          = (state_reg == S_HALT);
  assign bus.trap_misaligned = trap_reg;
  assign bus.bad_addr        = bad_addr_reg;

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: directed test-plan scenarios followed
// by randomized stimulus, all compared against a behavioural model.
// Honours PC_STATS_EN the same way as the design build.
module tb_pc_update;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk;
  logic rstn;

  pc_update_if #(.XLEN(32)) bus ();

  pc_update #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_trap;
  logic [31:0] m_bad;
  logic [31:0] m_ret;
  logic [31:0] m_tkn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic st, input logic tk, input logic jr,
                       input logic [31:0] im, input logic [31:0] rs);
    bus.stall    = st;
    bus.taken    = tk;
    bus.jalr     = jr;
    bus.imm      = im;
    bus.rs1_data = rs;
  endtask

  // Next-state rules of the PC stage, written from the behavioural description
  task automatic model_edge();
    logic [31:0] tgt;
    if (!rstn) begin
      m_pc = RST_PC; m_halt = 1'b0; m_trap = 1'b0; m_bad = 32'd0;
      m_ret = 32'd0; m_tkn = 32'd0;
    end else if (m_halt || bus.stall) begin
      m_trap = 1'b0;
    end else begin
      if (bus.jalr) tgt = (bus.rs1_data + bus.imm) & 32'hFFFF_FFFE;
      else          tgt = m_pc + bus.imm;
      if (bus.taken && (tgt % 4 != 0)) begin
        m_halt = 1'b1; m_trap = 1'b1; m_bad = tgt;
      end else begin
        m_trap = 1'b0;
        m_pc   = bus.taken ? tgt : m_pc + 32'd4;
        m_ret  = m_ret + 32'd1;
        if (bus.taken) m_tkn = m_tkn + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_ret;
    logic [31:0] exp_tkn;
`ifdef PC_STATS_EN
    exp_ret = m_ret;
    exp_tkn = m_tkn;
`else
    exp_ret = 32'd0;
    exp_tkn = 32'd0;
`endif
    check("pc",       bus.pc,                       m_pc);
    check("pc_plus4", bus.pc_plus4,                 m_pc + 32'd4);
    check("halted",   {31'd0, bus.halted},          {31'd0, m_halt});
    check("trap",     {31'd0, bus.trap_misaligned}, {31'd0, m_trap});
    check("bad_addr", bus.bad_addr,                 m_bad);
    check("retired",  bus.retired_cnt,              exp_ret);
    check("taken",    bus.taken_cnt,                exp_tkn);
  endtask

  // One clock edge: model follows the sampled inputs, outputs checked 1 time unit later
  task automatic step(input string what);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
    $display("cyc %0d %-10s rstn=%b st=%b tk=%b jr=%b pc=%h halted=%b trap=%b bad=%h",
             cyc, what, rstn, bus.stall, bus.taken, bus.jalr, bus.pc,
             bus.halted, bus.trap_misaligned, bus.bad_addr);
  endtask

  initial begin
    m_pc = 32'd0; m_halt = 1'b0; m_trap = 1'b0; m_bad = 32'd0;
    m_ret = 32'd0; m_tkn = 32'd0;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step("reset");
    step("reset");

    // Sequential fetch from RESET_PC
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step("seq");
    check("seq_pc_end", bus.pc, 32'h0000_010C);

    // Redirects: to 0x200, then pc-relative -8, then jalr with bit 0 cleared
    drive(1'b0, 1'b1, 1'b0, 32'h0000_00F4, 32'd0);  step("jal");
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);  step("branch");
    check("branch_pc", bus.pc, 32'h0000_01F8);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_1001);  step("jalr");
    check("jalr_pc", bus.pc, 32'h0000_1004);

    // Stall holds everything for 4 cycles, then the redirect lands
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
    for (int i = 0; i < 4; i++) step("stall");
    bus.stall = 1'b0;  step("unstall");
    check("unstall_pc", bus.pc, 32'h0000_1044);

    // Go to 0x300, then misaligned branch +6 halts
    drive(1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0300);  step("to300");
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'd0);  step("misalign");
    check("halt_bad", bus.bad_addr, 32'h0000_0306);
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      step("halt_rand");
    end
    check("halt_pc", bus.pc, 32'h0000_0300);
    rstn = 1'b0;  step("reset");
    rstn = 1'b1;

    // Sequential wrap at the top of the address space; taken=0 ignores odd imm
    drive(1'b0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFC);  step("toTop");
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0003, 32'd0);  step("wrap");
    check("wrap_pc", bus.pc, 32'd0);

    // Misaligned with stall does not halt; first unstalled edge does
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0002, 32'd0);
    step("st_mis");
    step("st_mis");
    bus.stall = 1'b0;  step("mis_now");

    // Reset overrides a would-be halting edge
    rstn = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'd0);  step("rst_mis");
    rstn = 1'b1;

    // Randomized stimulus: mostly aligned immediates, rare faults and resets
    for (int i = 0; i < 400; i++) begin
      logic [31:0] im;
      logic [31:0] rs;
      im = $urandom & 32'hFFFF_FFFC;
      rs = $urandom & 32'hFFFF_FFFD;
      if ($urandom_range(0, 31) == 0) im = im | 32'($urandom_range(1, 3));
      drive($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), im, rs);
      rstn = ($urandom_range(0, 39) != 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
